// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared state encoding and constants for the serial pattern blocks
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } seq_state_e;

  localparam logic       IDLE_BIT_DEFAULT = 1'b0;
  localparam logic [3:0] PAT_1011         = 4'b1011;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// seq_pattern_tx : repeats a latched WIDTH-bit pattern MSB-first on a serial line
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             x,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             x_q, x_d;
  logic             bv_q, bv_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are decided one cycle ahead so every flag leaves a flop.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gcnt_d    = gcnt_q;
    idx_d     = idx_q;
    x_d       = IDLE_BIT;
    bv_d      = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reps != '0) begin
            pat_d     = pattern;
            rem_d     = reps;
            gap_len_d = gap;
            idx_d     = IDX_MSB;
            state_d   = S_SHIFT;
            x_d       = pattern[WIDTH-1];
            bv_d      = 1'b1;
            fs_d      = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d  = idx_q - IDX_W'(1);
          x_d    = pat_q[idx_d];
          bv_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_len_q == '0) begin
            idx_d  = IDX_MSB;
            x_d    = pat_q[WIDTH-1];
            bv_d   = 1'b1;
            fs_d   = 1'b1;
            busy_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gcnt_d  = gap_len_q;
            busy_d  = 1'b1;
          end
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        // gcnt_q counts the gap cycles still to be shown, including this one.
        if (gcnt_q == CNT_W'(1)) begin
          gcnt_d  = '0;
          state_d = S_SHIFT;
          idx_d   = IDX_MSB;
          x_d     = pat_q[WIDTH-1];
          bv_d    = 1'b1;
          fs_d    = 1'b1;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      rem_q     <= '0;
      gap_len_q <= '0;
      gcnt_q    <= '0;
      idx_q     <= '0;
      x_q       <= IDLE_BIT;
      bv_q      <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gcnt_q    <= gcnt_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      bv_q      <= bv_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x           = x_q;
  assign bit_valid   = bv_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : seq_pattern_tx

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// tb_seq_pattern_tx : directed and randomized checks of seq_pattern_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  pattern;
  logic [CW-1:0] reps;
  logic [CW-1:0] gap;
  logic          x, bit_valid, frame_start, busy, done;

  int passes = 0;
  int total  = 0;

  // Expected per-cycle output word: {x, bit_valid, frame_start, busy, done}
  logic [4:0] exp_q[$];

  localparam logic [4:0] IDLE_W = 5'b00000;

  seq_pattern_tx #(.WIDTH(W), .CNT_W(CW), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps), .gap(gap),
    .x(x), .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stream model: reps frames of the pattern, gap idle-but-busy cycles between, then done.
  function automatic void model(input logic [W-1:0] p, input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = W - 1; b >= 0; b--)
        exp_q.push_back({p[b], 1'b1, (b == W - 1), 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00001);
  endfunction

  task automatic check(input string tag, input logic [4:0] e);
    logic [4:0] obs;
    obs = {x, bit_valid, frame_start, busy, done};
    total = total + 1;
    assert (obs === e) passes = passes + 1;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, e);
  endtask

  // Walk the expected queue one cycle at a time; start drops after index drop_at,
  // after which inputs may be scrambled to prove they are ignored.
  task automatic play(input string tag, input int drop_at, input bit scramble);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
      if (i == drop_at) start = 1'b0;
      else if (i > drop_at && scramble) begin
        start   = 1'($urandom);
        pattern = W'($urandom);
        reps    = CW'($urandom);
        gap     = CW'($urandom);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle"}, IDLE_W);
    exp_q.delete();
  endtask

  task automatic tx(input string tag, input logic [W-1:0] p, input int r, input int g);
    @(negedge clk);
    start = 1'b1; pattern = p; reps = CW'(r); gap = CW'(g);
    model(p, r, g);
    play(tag, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
    repeat (3) @(posedge clk);
    #1 check("reset", IDLE_W);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check("post_reset", IDLE_W);

    tx("single", PAT_1011, 1, 0);
    tx("b2b3", PAT_1011, 3, 0);
    tx("gap2", PAT_1011, 2, 2);
    tx("reps0", PAT_1011, 0, 3);

    // Competing start with another pattern on the second bit is ignored.
    @(negedge clk);
    start = 1'b1; pattern = PAT_1011; reps = 4'd1; gap = 4'd0;
    model(PAT_1011, 1, 0);
    @(posedge clk); #1 check("ign[0]", exp_q[0]); start = 1'b0;
    @(posedge clk); #1 check("ign[1]", exp_q[1]); start = 1'b1; pattern = 4'b0110;
    @(posedge clk); #1 check("ign[2]", exp_q[2]); start = 1'b0;
    @(posedge clk); #1 check("ign[3]", exp_q[3]);
    @(posedge clk); #1 check("ign[4]", exp_q[4]);
    @(posedge clk); #1 check("ign_idle", IDLE_W);
    exp_q.delete();

    // start held high: one IDLE cycle between back-to-back transmissions.
    @(negedge clk);
    start = 1'b1; pattern = 4'b1101; reps = 4'd1; gap = 4'd0;
    model(4'b1101, 1, 0);
    exp_q.push_back(IDLE_W);
    model(4'b1101, 1, 0);
    play("held", W + 2, 1'b0);

    // Reset during the third bit aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; pattern = 4'b1001; reps = 4'd2; gap = 4'd1;
    model(4'b1001, 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check($sformatf("abort[%0d]", i), exp_q[i]);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1 check("abort_rst", IDLE_W);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check($sformatf("abort_quiet%0d", i), IDLE_W);
    end
    exp_q.delete();
    tx("after_rst", 4'b0111, 2, 0);

    tx("max_reps", 4'b1010, (1 << CW) - 1, 1);

    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] p;
      int r, g;
      p = W'($urandom);
      r = int'($urandom_range(0, 5));
      g = int'($urandom_range(0, 4));
      tx($sformatf("rnd%0d", n), p, r, g);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_seq_pattern_tx

`default_nettype wire
